// File: rtl/axi_s_hdr_filter_pkg.sv
// Shared types and constants for the packet AXI-Stream header filter:
// FSM encoding, header field byte positions and the beat register layout.
package axi_s_hdr_filter_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_PASS  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

    localparam int MAC_BYTES  = 6;
    localparam int ET_BYTE_HI = 4;
    localparam int ET_BYTE_LO = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              valid;
    } beat_t;

    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d, input int unsigned n);
        return d[8*n +: 8];
    endfunction

endpackage

// File: rtl/axi_s_hdr_filter.sv
// Frame filter on destination MAC (beat 0) and EtherType (beat 1); matching
// frames are forwarded through a hold/output register pair, others are swallowed.
module axi_s_hdr_filter
    import axi_s_hdr_filter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          s_packet_axis_tdata,
    input  logic                 s_packet_axis_tvalid,
    input  logic                 s_packet_axis_tlast,
    input  logic [7:0]           s_packet_axis_tkeep,
    output logic                 s_packet_axis_tready,
    output logic [63:0]          m_packet_axis_tdata,
    output logic                 m_packet_axis_tvalid,
    output logic                 m_packet_axis_tlast,
    output logic [7:0]           m_packet_axis_tkeep,
    input  logic                 m_packet_axis_tready,
    input  logic                 cfg_mac_en,
    input  logic [47:0]          cfg_mac,
    input  logic                 cfg_ethertype_en,
    input  logic [15:0]          cfg_ethertype,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] runt_cnt
);

    logic [2:0]           r_state;
    beat_t                r_h;
    beat_t                r_o;
    beat_t                w_in;
    logic [CNT_WIDTH-1:0] r_pass_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] r_runt_cnt;

    logic                 w_o_free;
    logic                 w_tready;
    logic                 w_accept;
    logic                 w_mac_eq;
    logic                 w_et_eq;
    logic                 w_match;

    assign w_o_free = !r_o.valid || m_packet_axis_tready;
    assign w_accept = s_packet_axis_tvalid && w_tready;

    always_comb begin
        w_in.data  = s_packet_axis_tdata;
        w_in.keep  = s_packet_axis_tkeep;
        w_in.last  = s_packet_axis_tlast;
        w_in.valid = 1'b1;
    end

    // Beat 0 sits in H while beat 1 is on the input, so both fields are visible together.
    always_comb begin
        w_mac_eq = 1'b1;
        for (int i = 0; i < MAC_BYTES; i++) begin
            if (get_byte(r_h.data, i) != cfg_mac[8*(MAC_BYTES-1-i) +: 8]) begin
                w_mac_eq = 1'b0;
            end
        end
    end

    assign w_et_eq = ({get_byte(s_packet_axis_tdata, ET_BYTE_HI),
                       get_byte(s_packet_axis_tdata, ET_BYTE_LO)} == cfg_ethertype);
    assign w_match = (!cfg_mac_en || w_mac_eq) && (!cfg_ethertype_en || w_et_eq);

    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            ST_IDLE, ST_DROP: w_tready = 1'b1;
            ST_HDR, ST_PASS:  w_tready = w_o_free;
            default:          w_tready = 1'b0;
        endcase
        if (rst) begin
            w_tready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_h        <= '0;
            r_o        <= '0;
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
            r_runt_cnt <= '0;
        end else begin
            // A consumed output beat frees O unless a new beat is loaded below.
            if (m_packet_axis_tready) begin
                r_o.valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_h       <= w_in;
                        r_h.valid <= !s_packet_axis_tlast;
                        if (s_packet_axis_tlast) begin
                            r_runt_cnt <= r_runt_cnt + 1'b1;
                        end else begin
                            r_state <= ST_HDR;
                        end
                    end
                end

                ST_HDR: begin
                    if (w_accept) begin
                        if (w_match) begin
                            r_o        <= r_h;
                            r_h        <= w_in;
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                            r_state    <= s_packet_axis_tlast ? ST_FLUSH : ST_PASS;
                        end else begin
                            r_h.valid  <= 1'b0;
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                            r_state    <= s_packet_axis_tlast ? ST_IDLE : ST_DROP;
                        end
                    end
                end

                ST_PASS: begin
                    if (w_accept) begin
                        r_o <= r_h;
                        r_h <= w_in;
                        if (s_packet_axis_tlast) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (w_o_free) begin
                        r_o       <= r_h;
                        r_h.valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (w_accept && s_packet_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_packet_axis_tready = w_tready;
    assign m_packet_axis_tdata  = r_o.data;
    assign m_packet_axis_tkeep  = r_o.keep;
    assign m_packet_axis_tlast  = r_o.last;
    assign m_packet_axis_tvalid = r_o.valid;
    assign pass_cnt             = r_pass_cnt;
    assign drop_cnt             = r_drop_cnt;
    assign runt_cnt             = r_runt_cnt;

endmodule

// File: tb/tb_axi_s_hdr_filter.sv
// Bench for axi_s_hdr_filter: directed scenarios plus random frames, scored
// against a frame-level model of the filtering rules.
module tb_axi_s_hdr_filter;

    logic        clk;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [7:0]  s_tkeep;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [7:0]  m_tkeep;
    logic        m_tready;
    logic        cfg_mac_en;
    logic [47:0] cfg_mac;
    logic        cfg_ethertype_en;
    logic [15:0] cfg_ethertype;
    logic [31:0] pass_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] runt_cnt;

    axi_s_hdr_filter #(.CNT_WIDTH(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_packet_axis_tdata  (s_tdata),
        .s_packet_axis_tvalid (s_tvalid),
        .s_packet_axis_tlast  (s_tlast),
        .s_packet_axis_tkeep  (s_tkeep),
        .s_packet_axis_tready (s_tready),
        .m_packet_axis_tdata  (m_tdata),
        .m_packet_axis_tvalid (m_tvalid),
        .m_packet_axis_tlast  (m_tlast),
        .m_packet_axis_tkeep  (m_tkeep),
        .m_packet_axis_tready (m_tready),
        .cfg_mac_en           (cfg_mac_en),
        .cfg_mac              (cfg_mac),
        .cfg_ethertype_en     (cfg_ethertype_en),
        .cfg_ethertype        (cfg_ethertype),
        .pass_cnt             (pass_cnt),
        .drop_cnt             (drop_cnt),
        .runt_cnt             (runt_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [72:0] exp_q[$];
    logic [72:0] got_q[$];
    logic [31:0] exp_pass = 0;
    logic [31:0] exp_drop = 0;
    logic [31:0] exp_runt = 0;

    logic [63:0] f_data[8];
    logic [7:0]  f_keep_last;
    int          f_len  = 0;
    bit          f_pass = 0;

    int          bp_mode    = 0;
    int          bp_cnt     = 0;
    int          cyc        = 0;
    int          b1_cyc     = 0;
    int          first_cyc  = 0;
    bit          first_seen = 1;
    bit          prev_stall = 0;
    logic [73:0] prev_v     = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] keep_of(input int i);
        return (i == f_len - 1) ? f_keep_last : 8'hFF;
    endfunction

    // m_tready driver and output monitor share one process so ordering is fixed.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (bp_cnt % 3 == 0);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            bp_cnt++;
            #2;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", 128'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 128'(prev_v));
                if (!first_seen && m_tvalid) begin
                    first_seen = 1;
                    first_cyc  = cyc;
                end
                if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tkeep, m_tlast});
                prev_stall = m_tvalid && !m_tready;
                prev_v     = {m_tvalid, m_tdata, m_tkeep, m_tlast};
            end
        end
    end

    task automatic make_frame(input int len, input bit mac_m, input bit et_m);
        f_len       = len;
        f_keep_last = 8'($urandom_range(1, 255));
        for (int i = 0; i < len; i++) f_data[i] = {$urandom, $urandom};
        if (mac_m)
            for (int b = 0; b < 6; b++) f_data[0][8*b +: 8] = cfg_mac[8*(5-b) +: 8];
        if (et_m && len > 1) begin
            f_data[1][39:32] = cfg_ethertype[15:8];
            f_data[1][47:40] = cfg_ethertype[7:0];
        end
    endtask

    // Frame-level reference: runt, forward whole frame, or drop whole frame.
    task automatic model_frame();
        logic [63:0] d0;
        logic [63:0] d1;
        logic [47:0] mac;
        logic [15:0] et;
        if (f_len == 1) begin
            exp_runt++;
            f_pass = 0;
        end else begin
            d0  = f_data[0];
            d1  = f_data[1];
            mac = {d0[7:0], d0[15:8], d0[23:16], d0[31:24], d0[39:32], d0[47:40]};
            et  = {d1[39:32], d1[47:40]};
            f_pass = (!cfg_mac_en || mac == cfg_mac) && (!cfg_ethertype_en || et == cfg_ethertype);
            if (f_pass) begin
                exp_pass++;
                for (int i = 0; i < f_len; i++)
                    exp_q.push_back({f_data[i], keep_of(i), i == f_len - 1});
            end else begin
                exp_drop++;
            end
        end
    endtask

    task automatic send_frame(input int nbeats, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            int waitc;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            s_tdata  = f_data[i];
            s_tkeep  = keep_of(i);
            s_tlast  = (i == f_len - 1);
            s_tvalid = 1'b1;
            waitc    = 0;
            forever begin
                #1;
                if (i >= 1 && f_pass && m_tvalid && !m_tready)
                    chk("tready_when_o_full", 128'(s_tready), 128'(0));
                if (waitc == 0 && i >= 1 && !f_pass && bp_mode == 0)
                    chk("drop_tready", 128'(s_tready), 128'(1));
                if (s_tready || waitc >= 500) break;
                @(negedge clk);
                waitc++;
            end
            chk("beat_accepted", 128'(s_tready), 128'(1));
            if (!s_tready) begin
                s_tvalid = 1'b0;
                return;
            end
            if (i == 1) b1_cyc = cyc;
            @(posedge clk);
            #1 s_tvalid = 1'b0;
        end
    endtask

    task automatic check_stream(input string name);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        #3;
        chk({name, "_beats"}, 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
        chk({name, "_pass_cnt"}, 128'(pass_cnt), 128'(exp_pass));
        chk({name, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drop));
        chk({name, "_runt_cnt"}, 128'(runt_cnt), 128'(exp_runt));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst              = 1'b1;
        s_tvalid         = 1'b0;
        s_tdata          = '0;
        s_tkeep          = '0;
        s_tlast          = 1'b0;
        cfg_mac_en       = 1'b0;
        cfg_mac          = '0;
        cfg_ethertype_en = 1'b0;
        cfg_ethertype    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1 chk("tready_in_reset", 128'(s_tready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tdata",  128'(m_tdata),  128'(0));
        chk("rst_m_tkeep",  128'(m_tkeep),  128'(0));
        chk("rst_m_tlast",  128'(m_tlast),  128'(0));
        chk("rst_pass_cnt", 128'(pass_cnt), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_runt_cnt", 128'(runt_cnt), 128'(0));

        // MAC filter pass, 8 beats, latency of first output beat
        cfg_mac_en = 1'b1;
        cfg_mac    = 48'h02_00_00_00_00_01;
        first_seen = 0;
        make_frame(8, 1, 0);
        model_frame();
        send_frame(8, 0);
        check_stream("mac_pass");
        chk("first_out_seen", 128'(first_seen), 128'(1));
        chk("first_out_latency", 128'(first_cyc), 128'(b1_cyc + 1));

        // EtherType filter drop
        cfg_mac_en       = 1'b0;
        cfg_ethertype_en = 1'b1;
        cfg_ethertype    = 16'h0800;
        make_frame(4, 0, 0);
        f_data[1][39:32] = 8'h86;
        f_data[1][47:40] = 8'hDD;
        model_frame();
        send_frame(4, 0);
        check_stream("et_drop");

        // Runt then a 2-beat matching frame
        make_frame(1, 0, 0);
        model_frame();
        send_frame(1, 0);
        make_frame(2, 0, 1);
        model_frame();
        send_frame(2, 0);
        check_stream("runt_then_pass");

        // Output backpressure 1,0,0,1,...
        bp_mode = 1;
        bp_cnt  = 0;
        make_frame(5, 0, 1);
        model_frame();
        send_frame(5, 0);
        check_stream("backpressure");
        bp_mode = 0;

        // Back-to-back pass, drop, pass
        make_frame(3, 0, 1);
        model_frame();
        send_frame(3, 0);
        make_frame(4, 0, 0);
        f_data[1][47:40] = ~cfg_ethertype[7:0];
        model_frame();
        send_frame(4, 0);
        make_frame(3, 0, 1);
        model_frame();
        send_frame(3, 0);
        check_stream("back_to_back");

        // Reset during beat 3 of a passing frame
        cfg_mac_en       = 1'b1;
        cfg_ethertype_en = 1'b0;
        make_frame(6, 1, 0);
        f_pass = 1;
        send_frame(3, 0);
        @(negedge clk);
        rst      = 1'b1;
        s_tdata  = f_data[3];
        s_tkeep  = 8'hFF;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        #1 chk("tready_mid_reset", 128'(s_tready), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        s_tvalid = 1'b0;
        #3;
        chk("post_rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("post_rst_pass_cnt", 128'(pass_cnt), 128'(0));
        chk("post_rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("post_rst_runt_cnt", 128'(runt_cnt), 128'(0));
        got_q.delete();
        exp_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        exp_runt = 0;
        make_frame(3, 0, 0);
        model_frame();
        send_frame(3, 0);
        make_frame(2, 1, 0);
        model_frame();
        send_frame(2, 0);
        check_stream("after_reset");

        // Random frames, random gaps and output backpressure
        bp_mode = 2;
        for (int n = 0; n < 60; n++) begin
            int len;
            if (n % 10 == 0) begin
                cfg_mac_en       = 1'($urandom_range(0, 1));
                cfg_mac          = {16'($urandom), $urandom};
                cfg_ethertype_en = 1'($urandom_range(0, 1));
                cfg_ethertype    = 16'($urandom);
            end
            len = $urandom_range(1, 8);
            make_frame(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            model_frame();
            send_frame(len, 1);
        end
        check_stream("random");
        bp_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
